traffic_light_controller_param: RTL
===================================

# traffic_light_controller_param

Parametrised two-road intersection controller for main street, side street and pedestrian crossing. It extends the fixed-cycle controller with:
- configurable phase durations;
- all-red clearance intervals;
- sensor-driven early main termination and side-green extension;
- optional on-demand side service;
- a maintenance flash mode.

It runs on the 1 Hz system tick clock, so one cycle equals one second, and drives lamp outputs directly.

## Interface
- MAIN_GREEN_T, 12, main green duration in cycles
- MAIN_GREEN_MIN, 6, minimum main green before a sensor request may end it (1..MAIN_GREEN_T)
- YELLOW_T, 3, yellow duration, both roads
- ALL_RED_T, 1, all-red clearance duration
- SIDE_GREEN_T, 6, base side green duration
- SIDE_GREEN_EXT, 3, single extension added when sensor is still active
- WALK_T, 3, walk phase duration
- SIDE_ON_DEMAND, 0, 0 = side always served; 1 = side served only on request
- CNT_W, 8, elapsed-counter width; must hold max(MAIN_GREEN_T, SIDE_GREEN_T+SIDE_GREEN_EXT)
- clk  in  1  system clock, 1 cycle per second
- rst  in  1  synchronous, active-high reset
- walk_button  in  1  pedestrian request, level sampled every cycle
- sensor  in  1  side-street vehicle detector
- flash_mode  in  1  maintenance flash request, level
- main_green, main_yellow, main_red  out  1 each  main lamps
- side_green, side_yellow, side_red  out  1 each  side lamps
- walk_lamp  out  1  pedestrian walk lamp
- phase  out  3  current state code

## Operation
- States and codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, WALK=6, FLASH=7.
- Moore outputs are decoded from the registered state.
  - MG: main_green and side_red.
  - MY: main_yellow and side_red.
  - SG: main_red and side_green.
  - SY: main_red and side_yellow.
  - AR1, AR2, WALK: main_red and side_red; walk_lamp=1 only in WALK.
- Elapsed counter: cleared on every state entry, +1 per cycle, saturates at all-ones.
- A state of duration D exits on the edge where elapsed == D-1, so it lasts D cycles.
- sensor_req latch:
  - Set by sensor=1 in any state except SG, SY and FLASH.
  - Cleared on entry to SG and on entry to FLASH.
- walk_req latch:
  - Set by walk_button=1 in any state except FLASH.
  - Cleared on entry to WALK and on entry to FLASH.
- Decisions use pending = latch OR live input, so a request sampled on the deciding edge counts.
- Transitions, in priority order within each state:
  - MG:
    - flash_mode -> MY.
    - sensor pending and elapsed >= MAIN_GREEN_MIN-1 -> MY.
    - elapsed == MAIN_GREEN_T-1 -> MY, but when SIDE_ON_DEMAND=1 only if sensor or walk is pending; otherwise MG holds.
  - MY: after YELLOW_T -> AR1.
  - AR1: after ALL_RED_T:
    - flash_mode -> FLASH.
    - SIDE_ON_DEMAND=0 or sensor pending -> SG.
    - otherwise -> WALK.
  - SG:
    - flash_mode -> SY.
    - elapsed == SIDE_GREEN_T-1 and sensor=0 -> SY.
    - elapsed == SIDE_GREEN_T+SIDE_GREEN_EXT-1 -> SY.
    - At most one extension per service.
  - SY: after YELLOW_T -> AR2.
  - AR2: after ALL_RED_T:
    - flash_mode -> FLASH.
    - walk pending -> WALK.
    - otherwise -> MG.
  - WALK:
    - flash_mode -> AR2.
    - after WALK_T -> MG.
  - FLASH:
    - flash_mode=0 -> AR2; latches are already clear, so AR2 then goes to MG.
    - Otherwise stay.
- FLASH lamps:
  - main_yellow and side_red toggle in phase: 1 on the first FLASH cycle, 0 on the next, and so on.
  - All other lamps are 0.

## Timing
- Reset (rst high at an edge):
  - state=MG, elapsed=0, both latches cleared, flash toggle cleared.
  - Following cycle outputs: main_green=1, side_red=1, all others 0, phase=0.
- Reset overrides everything, including mid-WALK and mid-FLASH.
- Input-to-state latency is one edge.
- Lamp outputs change on the same edge as phase.
- Simultaneous events:
  - flash_mode beats every timer expiry.
  - Sensor and walk both pending at AR2: WALK first; sensor_req survives to the next cycle.
- A walk press during WALK re-arms walk_req after the clear and is served next cycle.
- No green is ever followed directly by an opposing green; yellow and all-red always intervene.
- Every cycle has exactly one lamp lit per road, except in FLASH.

## Test plan
- Defaults, no inputs, from reset -> repeating 26-cycle period: MG 12, MY 3, AR1 1, SG 6, SY 3, AR2 1; walk_lamp never 1.
- Sensor pulsed 1 cycle at MG elapsed 2 -> MG lasts 6 cycles. Then MY 3, AR1 1, SG 6.
- Sensor held high through SG -> SG lasts 9 cycles then SY.
  - Sensor dropping at SG elapsed 4 -> SG lasts 6.
- walk_button pulse during SG -> after AR2: WALK 3 cycles with walk_lamp=1 and both roads red, then MG.
- SIDE_ON_DEMAND=1, no inputs -> MG holds indefinitely.
  - Then a walk press -> MY, AR1, WALK, MG; SG is skipped.
- flash_mode=1 at MG elapsed 3 -> MY 3, AR1 1, then FLASH with main_yellow/side_red toggling 1,0,1.
  - flash_mode=0 -> AR2 1 cycle -> MG.
  - rst asserted mid-FLASH -> MG next cycle.

Source files
------------

// File: rtl/traffic_light_controller_param.sv
// Purpose: two-road intersection controller (main, side, pedestrian) with tunable phase timing and a flash mode.
// Latency: inputs are sampled on one edge; the state, phase and lamps change on that same edge.
// Backpressure: none. The inputs are levels sampled every cycle, and requests are held in latches until served.
module traffic_light_controller_param #(
  parameter int unsigned MAIN_GREEN_T   = 12,
  parameter int unsigned MAIN_GREEN_MIN = 6,
  parameter int unsigned YELLOW_T       = 3,
  parameter int unsigned ALL_RED_T      = 1,
  parameter int unsigned SIDE_GREEN_T   = 6,
  parameter int unsigned SIDE_GREEN_EXT = 3,
  parameter int unsigned WALK_T         = 3,
  parameter int unsigned SIDE_ON_DEMAND = 0,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       walk_button,
  input  logic       sensor,
  input  logic       flash_mode,
  output logic       main_green,
  output logic       main_yellow,
  output logic       main_red,
  output logic       side_green,
  output logic       side_yellow,
  output logic       side_red,
  output logic       walk_lamp,
  output logic [2:0] phase
);

  // State codes are visible on the phase output, so they must keep these values.
  localparam logic [2:0] ST_MG    = 3'd0;
  localparam logic [2:0] ST_MY    = 3'd1;
  localparam logic [2:0] ST_AR1   = 3'd2;
  localparam logic [2:0] ST_SG    = 3'd3;
  localparam logic [2:0] ST_SY    = 3'd4;
  localparam logic [2:0] ST_AR2   = 3'd5;
  localparam logic [2:0] ST_WALK  = 3'd6;
  localparam logic [2:0] ST_FLASH = 3'd7;

  // A state of duration D leaves on the edge where elapsed equals D-1.
  localparam logic [CNT_W-1:0] MG_LAST     = CNT_W'(MAIN_GREEN_T - 1);
  localparam logic [CNT_W-1:0] MG_MIN_LAST = CNT_W'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] SG_LAST     = CNT_W'(SIDE_GREEN_T - 1);
  localparam logic [CNT_W-1:0] SG_EXT_LAST = CNT_W'(SIDE_GREEN_T + SIDE_GREEN_EXT - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic             ON_DEMAND   = (SIDE_ON_DEMAND != 0);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] elapsed;
  logic             sensor_req;
  logic             walk_req;
  logic             flash_on;

  logic sensor_pend;
  logic walk_pend;
  logic state_change;
  logic main_timer_done;

  // Requests seen on the deciding edge count, even if they were not latched before.
  assign sensor_pend  = sensor_req | sensor;
  assign walk_pend    = walk_req | walk_button;
  assign state_change = (state_nxt != state);

  // The main-green timer uses >= so that a green held by on-demand mode can still end
  // on a later request, after the elapsed count has gone past the nominal duration.
  assign main_timer_done = (elapsed >= MG_LAST) &&
                           (!ON_DEMAND || sensor_pend || walk_pend);

  // Next-state selection. Within each state, flash_mode is tested before any timer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_MG: begin
        if (flash_mode)
          state_nxt = ST_MY;
        else if (sensor_pend && (elapsed >= MG_MIN_LAST))
          state_nxt = ST_MY;
        else if (main_timer_done)
          state_nxt = ST_MY;
      end
      ST_MY: begin
        if (elapsed >= Y_LAST)
          state_nxt = ST_AR1;
      end
      ST_AR1: begin
        if (elapsed >= AR_LAST) begin
          if (flash_mode)
            state_nxt = ST_FLASH;
          else if (!ON_DEMAND || sensor_pend)
            state_nxt = ST_SG;
          else
            state_nxt = ST_WALK;
        end
      end
      ST_SG: begin
        // Only the live sensor can extend the green, and only once, up to SG_EXT_LAST.
        if (flash_mode)
          state_nxt = ST_SY;
        else if ((elapsed == SG_LAST) && !sensor)
          state_nxt = ST_SY;
        else if (elapsed >= SG_EXT_LAST)
          state_nxt = ST_SY;
      end
      ST_SY: begin
        if (elapsed >= Y_LAST)
          state_nxt = ST_AR2;
      end
      ST_AR2: begin
        if (elapsed >= AR_LAST) begin
          if (flash_mode)
            state_nxt = ST_FLASH;
          else if (walk_pend)
            state_nxt = ST_WALK;
          else
            state_nxt = ST_MG;
        end
      end
      ST_WALK: begin
        if (flash_mode)
          state_nxt = ST_AR2;
        else if (elapsed >= WALK_LAST)
          state_nxt = ST_MG;
      end
      ST_FLASH: begin
        // Leaving flash goes through all-red before any green.
        if (!flash_mode)
          state_nxt = ST_AR2;
      end
      default: state_nxt = ST_MG;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_MG;
    else
      state <= state_nxt;
  end

  // Elapsed counter: restarts on every state change, counts up, and stops at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      elapsed <= '0;
    else if (state_change)
      elapsed <= '0;
    else if (elapsed != '1)
      elapsed <= elapsed + 1'b1;
  end

  // Side-street request latch. It is cleared when the side green starts or flash starts.
  // While the side road is being served, it does not record new requests.
  always_ff @(posedge clk) begin
    if (rst)
      sensor_req <= 1'b0;
    else if (state_change && ((state_nxt == ST_SG) || (state_nxt == ST_FLASH)))
      sensor_req <= 1'b0;
    else if (sensor && (state != ST_SG) && (state != ST_SY) && (state != ST_FLASH))
      sensor_req <= 1'b1;
  end

  // Pedestrian request latch. It is cleared when walk or flash starts.
  // A press during WALK re-arms it, so another walk is requested.
  always_ff @(posedge clk) begin
    if (rst)
      walk_req <= 1'b0;
    else if (state_change && ((state_nxt == ST_WALK) || (state_nxt == ST_FLASH)))
      walk_req <= 1'b0;
    else if (walk_button && (state != ST_FLASH))
      walk_req <= 1'b1;
  end

  // Flash toggle: lit on the first flash cycle, then inverted every cycle; zero outside flash.
  always_ff @(posedge clk) begin
    if (rst)
      flash_on <= 1'b0;
    else if (state_nxt == ST_FLASH)
      flash_on <= (state == ST_FLASH) ? ~flash_on : 1'b1;
    else
      flash_on <= 1'b0;
  end

  // Moore lamp decode from the registered state and flash toggle.
  always_comb begin
    main_green  = 1'b0;
    main_yellow = 1'b0;
    main_red    = 1'b0;
    side_green  = 1'b0;
    side_yellow = 1'b0;
    side_red    = 1'b0;
    walk_lamp   = 1'b0;
    case (state)
      ST_MG: begin
        main_green = 1'b1;
        side_red   = 1'b1;
      end
      ST_MY: begin
        main_yellow = 1'b1;
        side_red    = 1'b1;
      end
      ST_SG: begin
        main_red   = 1'b1;
        side_green = 1'b1;
      end
      ST_SY: begin
        main_red    = 1'b1;
        side_yellow = 1'b1;
      end
      ST_WALK: begin
        main_red  = 1'b1;
        side_red  = 1'b1;
        walk_lamp = 1'b1;
      end
      ST_FLASH: begin
        main_yellow = flash_on;
        side_red    = flash_on;
      end
      default: begin
        main_red = 1'b1;
        side_red = 1'b1;
      end
    endcase
  end

  assign phase = state;

endmodule
